// File: rtl/interval_timer_ctrl.sv
// ============================================================================
// interval_timer_ctrl : drives an external limit counter (start/en/limit) and
// turns its done flag into one-shot or periodic ticks.   Rev 1.0
// ============================================================================
`default_nettype none

module interval_timer_ctrl #(
   parameter int CNT_W  = 8,
   parameter int PRE_W  = 4,
   parameter int TCNT_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              go,
   input  logic              stop,
   input  logic              periodic,
   input  logic [CNT_W-1:0]  period,
   input  logic [PRE_W-1:0]  prescale,
   input  logic              cnt_done,
   output logic              cnt_start,
   output logic              cnt_en,
   output logic [CNT_W-1:0]  cnt_limit,
   output logic              tick,
   output logic              busy,
   output logic              err,
   output logic [TCNT_W-1:0] tick_count
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_RUN  = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    limit_q, limit_d;
   logic [PRE_W-1:0]    pre_q, pre_d;
   logic [PRE_W-1:0]    pre_cnt_q, pre_cnt_d;
   logic                periodic_q, periodic_d;
   logic                tick_q, tick_d;
   logic                err_q, err_d;
   logic                busy_q, busy_d;
   logic [TCNT_W-1:0]   tick_count_q, tick_count_d;

   always_comb begin
      state_d      = state_q;
      limit_d      = limit_q;
      pre_d        = pre_q;
      pre_cnt_d    = pre_cnt_q;
      periodic_d   = periodic_q;
      tick_d       = 1'b0;
      err_d        = 1'b0;
      tick_count_d = tick_count_q;

      case (state_q)
         S_IDLE: begin
            pre_cnt_d = '0;
            // stop has priority over go, and also suppresses the period==0 error
            if (go && !stop) begin
               if (period == '0) begin
                  err_d = 1'b1;
               end else begin
                  limit_d      = period;
                  pre_d        = prescale;
                  periodic_d   = periodic;
                  tick_count_d = '0;
                  state_d      = S_LOAD;
               end
            end
         end
         S_LOAD: begin
            pre_cnt_d = '0;
            state_d   = stop ? S_IDLE : S_RUN;
         end
         S_RUN: begin
            pre_cnt_d = (pre_cnt_q == pre_q) ? '0 : pre_cnt_q + PRE_W'(1);
            if (stop) begin
               state_d = S_IDLE;
            end else if (cnt_done) begin
               tick_d = 1'b1;
               if (!(&tick_count_q)) begin
                  tick_count_d = tick_count_q + TCNT_W'(1);
               end
               state_d = periodic_q ? S_LOAD : S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         limit_q      <= '0;
         pre_q        <= '0;
         pre_cnt_q    <= '0;
         periodic_q   <= 1'b0;
         tick_q       <= 1'b0;
         err_q        <= 1'b0;
         busy_q       <= 1'b0;
         tick_count_q <= '0;
      end else begin
         state_q      <= state_d;
         limit_q      <= limit_d;
         pre_q        <= pre_d;
         pre_cnt_q    <= pre_cnt_d;
         periodic_q   <= periodic_d;
         tick_q       <= tick_d;
         err_q        <= err_d;
         busy_q       <= busy_d;
         tick_count_q <= tick_count_d;
      end
   end

   // Enable is masked by done so the counter never steps past its limit.
   assign cnt_start  = (state_q == S_LOAD);
   assign cnt_en     = (state_q == S_RUN) && (pre_cnt_q == pre_q) && !cnt_done;
   assign cnt_limit  = limit_q;
   assign tick       = tick_q;
   assign busy       = busy_q;
   assign err        = err_q;
   assign tick_count = tick_count_q;

endmodule

`default_nettype wire
